// File: rtl/ysyx_22050598_muldiv_pkg.sv
// rtl/ysyx_22050598_muldiv_pkg.sv - shared widths, state encodings and op decode for the muldiv sequencer
package ysyx_22050598_muldiv_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = 7;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_MUL  = ST_MUL,
      S_DIV  = ST_DIV,
      S_FIX  = ST_FIX,
      S_DONE = ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_MUL = 2'd0,
      OP_DIV = 2'd1,
      OP_REM = 2'd2
   } op_t;

   localparam logic [CNT_W-1:0] CNT_WORD  = CNT_W'(32);
   localparam logic [CNT_W-1:0] CNT_DWORD = CNT_W'(64);

   // Magnitude of the most negative dividend, used to spot min / -1.
   localparam logic [XLEN-1:0] WORD_MIN_ABS  = {{(XLEN-32){1'b0}}, 32'h8000_0000};
   localparam logic [XLEN-1:0] DWORD_MIN_ABS = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

endpackage

// File: rtl/ysyx_22050598_muldiv_signfix.sv
// rtl/ysyx_22050598_muldiv_signfix.sv - operand abs/sign extraction and result negate/select/sign-extend
module ysyx_22050598_muldiv_signfix
   import ysyx_22050598_muldiv_pkg::*;
(
   input  logic [XLEN-1:0]   src1,
   input  logic [XLEN-1:0]   src2,
   input  logic              src1_signed,
   input  logic              src2_signed,
   input  logic              is_word,
   output logic [XLEN-1:0]   ext1,
   output logic [XLEN-1:0]   abs1,
   output logic [XLEN-1:0]   abs2,
   output logic              neg1,
   output logic              neg2,
   input  logic [2*XLEN-1:0] fix_in,
   input  logic              fix_neg,
   input  logic              fix_hi,
   input  logic              fix_word,
   output logic [XLEN-1:0]   fix_out
);
   logic [XLEN-1:0]   ext2;
   logic [2*XLEN-1:0] fix_signed;

   always_comb begin
      // Word ops work on the low half, widened by the operand's own signedness.
      ext1 = src1;
      ext2 = src2;
      if (is_word) begin
         ext1 = src1_signed ? sext32(src1) : {{(XLEN-32){1'b0}}, src1[31:0]};
         ext2 = src2_signed ? sext32(src2) : {{(XLEN-32){1'b0}}, src2[31:0]};
      end
      neg1 = src1_signed & ext1[XLEN-1];
      neg2 = src2_signed & ext2[XLEN-1];
      abs1 = neg1 ? -ext1 : ext1;
      abs2 = neg2 ? -ext2 : ext2;

      fix_signed = fix_neg ? -fix_in : fix_in;
      fix_out    = fix_hi ? fix_signed[2*XLEN-1:XLEN] : fix_signed[XLEN-1:0];
      if (fix_word)
         fix_out = sext32(fix_out);
   end

endmodule

// File: rtl/ysyx_22050598_muldiv_seq.sv
// rtl/ysyx_22050598_muldiv_seq.sv - iterative RV64M shift-add multiplier / restoring divider sequencer
module ysyx_22050598_muldiv_seq
   import ysyx_22050598_muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            muldiv_valid,
   input  logic            exu_is_mul,
   input  logic            exu_is_div,
   input  logic            exu_is_rem,
   input  logic            mul_hi,
   input  logic            src1_signed,
   input  logic            src2_signed,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            muldiv_flush,
   output logic            muldiv_ready,
   output logic            muldivout_valid,
   output logic [XLEN-1:0] muldiv_result
);
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc, mcand;
   logic [XLEN-1:0]   sreg, dvs, rem;
   op_t               op_q, op_in;
   logic              quo_neg_q, rem_neg_q, hi_q, word_q;

   logic [XLEN-1:0]   ext1, abs1, abs2, fix_out, fast_result, min_abs;
   logic              neg1, neg2, accept, div_zero, div_ovf, fast;
   logic [XLEN:0]     rem_sh, diff;
   logic [2*XLEN-1:0] fix_in;
   logic              fix_neg;

   ysyx_22050598_muldiv_signfix u_signfix (
      .src1        (src1),
      .src2        (src2),
      .src1_signed (src1_signed),
      .src2_signed (src2_signed),
      .is_word     (is_word),
      .ext1        (ext1),
      .abs1        (abs1),
      .abs2        (abs2),
      .neg1        (neg1),
      .neg2        (neg2),
      .fix_in      (fix_in),
      .fix_neg     (fix_neg),
      .fix_hi      ((op_q == OP_MUL) & hi_q),
      .fix_word    (word_q),
      .fix_out     (fix_out)
   );

   always_comb begin
      op_in = OP_MUL;
      if (exu_is_rem) op_in = OP_REM;
      if (exu_is_div) op_in = OP_DIV;
      if (exu_is_mul) op_in = OP_MUL;

      accept   = (state == S_IDLE) & muldiv_valid & ~muldiv_flush;
      min_abs  = is_word ? WORD_MIN_ABS : DWORD_MIN_ABS;
      div_zero = (abs2 == '0);
      div_ovf  = neg1 & neg2 & (abs1 == min_abs) & (abs2 == XLEN'(1));
      fast     = (exu_is_div | exu_is_rem) & ~exu_is_mul & (div_zero | div_ovf);
      if (div_zero)
         fast_result = exu_is_div ? '1 : (is_word ? sext32(src1) : src1);
      else
         fast_result = exu_is_div ? ext1 : '0;

      // Restoring step: the extra top bit of the shifted remainder carries out of XLEN.
      rem_sh = {rem, sreg[XLEN-1]};
      diff   = rem_sh - {1'b0, dvs};

      case (op_q)
         OP_MUL:  fix_in = acc;
         OP_DIV:  fix_in = {{XLEN{1'b0}}, sreg};
         default: fix_in = {{XLEN{1'b0}}, rem};
      endcase
      fix_neg = (op_q == OP_REM) ? rem_neg_q : quo_neg_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      muldiv_ready    = (state == S_IDLE);
      muldivout_valid = (state == S_DONE);
      case (state)
         S_IDLE:       if (accept) state_nxt = fast ? S_DONE : (exu_is_mul ? S_MUL : S_DIV);
         S_MUL, S_DIV: if (cnt == CNT_W'(1)) state_nxt = S_FIX;
         S_FIX:        state_nxt = S_DONE;
         S_DONE:       state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
      if (muldiv_flush)
         state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt           <= '0;
         acc           <= '0;
         mcand         <= '0;
         sreg          <= '0;
         dvs           <= '0;
         rem           <= '0;
         op_q          <= OP_MUL;
         quo_neg_q     <= 1'b0;
         rem_neg_q     <= 1'b0;
         hi_q          <= 1'b0;
         word_q        <= 1'b0;
         muldiv_result <= '0;
      end else if (muldiv_flush) begin
         cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (muldiv_valid) begin
               cnt       <= is_word ? CNT_WORD : CNT_DWORD;
               op_q      <= op_in;
               quo_neg_q <= neg1 ^ neg2;
               rem_neg_q <= neg1;
               hi_q      <= mul_hi;
               word_q    <= is_word;
               acc       <= '0;
               rem       <= '0;
               dvs       <= abs2;
               mcand     <= {{XLEN{1'b0}}, abs1};
               // Word dividends are left-aligned so the divider always consumes from the MSB.
               if (exu_is_mul)
                  sreg <= abs2;
               else
                  sreg <= is_word ? (abs1 << 32) : abs1;
               if (fast)
                  muldiv_result <= fast_result;
            end
            S_MUL: begin
               if (sreg[0])
                  acc <= acc + mcand;
               mcand <= mcand << 1;
               sreg  <= sreg >> 1;
               cnt   <= cnt - 1'b1;
            end
            S_DIV: begin
               rem  <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
               sreg <= {sreg[XLEN-2:0], ~diff[XLEN]};
               cnt  <= cnt - 1'b1;
            end
            S_FIX:   muldiv_result <= fix_out;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050598_muldiv_seq.sv
// tb/tb_ysyx_22050598_muldiv_seq.sv - randomized model-checked bench for the muldiv sequencer
module tb_ysyx_22050598_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n, muldiv_valid, exu_is_mul, exu_is_div, exu_is_rem, mul_hi;
   logic        src1_signed, src2_signed, is_word, muldiv_flush;
   logic [63:0] src1, src2;
   logic        muldiv_ready, muldivout_valid;
   logic [63:0] muldiv_result;

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;
   int          m_left = 0;
   logic [63:0] m_pend = '0;
   logic [63:0] m_last = '0;

   ysyx_22050598_muldiv_seq dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .muldiv_valid    (muldiv_valid),
      .exu_is_mul      (exu_is_mul),
      .exu_is_div      (exu_is_div),
      .exu_is_rem      (exu_is_rem),
      .mul_hi          (mul_hi),
      .src1_signed     (src1_signed),
      .src2_signed     (src2_signed),
      .is_word         (is_word),
      .src1            (src1),
      .src2            (src2),
      .muldiv_flush    (muldiv_flush),
      .muldiv_ready    (muldiv_ready),
      .muldivout_valid (muldivout_valid),
      .muldiv_result   (muldiv_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Flag order: mul div rem hi s1 s2 word
   function automatic logic [6:0] op_flags(input int k);
      case (k)
         0:  return 7'b1000110; // MUL
         1:  return 7'b1001110; // MULH
         2:  return 7'b1001100; // MULHSU
         3:  return 7'b1001000; // MULHU
         4:  return 7'b0100110; // DIV
         5:  return 7'b0100000; // DIVU
         6:  return 7'b0010110; // REM
         7:  return 7'b0010000; // REMU
         8:  return 7'b1000111; // MULW
         9:  return 7'b0100111; // DIVW
         10: return 7'b0100001; // DIVUW
         11: return 7'b0010111; // REMW
         default: return 7'b0010001; // REMUW
      endcase
   endfunction

   task automatic set_op(input int k);
      {exu_is_mul, exu_is_div, exu_is_rem, mul_hi, src1_signed, src2_signed, is_word} = op_flags(k);
   endtask

   function automatic logic [63:0] ext_op(input logic [63:0] v, input bit sgn, input bit w);
      if (!w) return v;
      return sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
   endfunction

   function automatic logic [63:0] ref_calc(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b);
      logic [63:0]  ea, eb, q, rm, r;
      logic [127:0] a128, b128, p;
      ea = ext_op(a, f[2], f[0]);
      eb = ext_op(b, f[1], f[0]);
      if (f[6]) begin
         a128 = f[2] ? {{64{ea[63]}}, ea} : {64'b0, ea};
         b128 = f[1] ? {{64{eb[63]}}, eb} : {64'b0, eb};
         p    = a128 * b128;
         r    = f[3] ? p[127:64] : p[63:0];
      end else begin
         if (eb == 64'd0) begin
            q = '1; rm = ea;
         end else if (f[2] && ea == 64'h8000_0000_0000_0000 && eb == '1) begin
            q = ea; rm = '0;
         end else if (f[2]) begin
            q  = $signed(ea) / $signed(eb);
            rm = $signed(ea) % $signed(eb);
         end else begin
            q  = ea / eb;
            rm = ea % eb;
         end
         r = f[5] ? q : rm;
      end
      if (f[0]) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   function automatic int ref_lat(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ea, eb, mn;
      int          full;
      ea   = ext_op(a, f[2], f[0]);
      eb   = ext_op(b, f[1], f[0]);
      full = f[0] ? 34 : 66;
      if (f[6]) return full;
      mn = f[0] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      if (eb == 64'd0 || (f[2] && f[1] && ea == mn && eb == '1)) return 1;
      return full;
   endfunction

   // m_left: cycles until the result cycle (1 = result visible now, 0 = idle).
   always @(posedge clk) begin
      logic [6:0] f;
      if (!rst_n) begin
         m_left = 0;
         m_last = '0;
      end else if (m_left == 0) begin
         if (muldiv_valid && !muldiv_flush) begin
            f      = {exu_is_mul, exu_is_div, exu_is_rem, mul_hi, src1_signed, src2_signed, is_word};
            m_pend = ref_calc(f, src1, src2);
            m_left = ref_lat(f, src1, src2);
         end
      end else if (m_left == 1) begin
         m_left = 0;
         m_last = m_pend;
      end else if (muldiv_flush) begin
         m_left = 0;
      end else begin
         m_left = m_left - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_ready", {63'b0, muldiv_ready}, {63'b0, m_left == 0});
         chk("model_valid", {63'b0, muldivout_valid}, {63'b0, m_left == 1});
         chk("model_result", muldiv_result, (m_left == 1) ? m_pend : m_last);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
      int c;
      set_op(k);
      src1 = a;
      src2 = b;
      muldiv_valid = 1'b1;
      c = 0;
      do begin
         @(posedge clk);
         c++;
         @(negedge clk);
      end while (!muldivout_valid && c < 200);
      chk({name, "_lat"}, 64'(c), 64'(exp_lat));
      chk({name, "_res"}, muldiv_result, exp_res);
      tick();
      muldiv_valid = 1'b0;
   endtask

   function automatic logic [63:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return '1;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'h0000_0000_8000_0000;
         5: return {$urandom, $urandom};
         6: return 64'($urandom_range(0, 20));
         default: return 64'd0 - 64'($urandom_range(1, 20));
      endcase
   endfunction

   initial begin
      bit saw;
      rst_n = 1'b0; muldiv_valid = 1'b0; muldiv_flush = 1'b0;
      set_op(0); src1 = '0; src2 = '0;
      repeat (3) tick();
      chk_en = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {63'b0, muldiv_ready}, 64'd1);
      chk("rst_valid", {63'b0, muldivout_valid}, 64'd0);
      chk("rst_result", muldiv_result, 64'd0);
      tick();

      run_op("mul_7x6", 0, 64'd7, 64'd6, 64'd42, 66);
      run_op("mulh_m1", 1, '1, '1, 64'd0, 66);
      run_op("mulhu", 3, '1, 64'd2, 64'd1, 66);
      run_op("mulhsu", 2, '1, 64'd2, '1, 66);
      run_op("div_m7_2", 4, 64'd0 - 64'd7, 64'd2, 64'd0 - 64'd3, 66);
      run_op("rem_m7_2", 6, 64'd0 - 64'd7, 64'd2, '1, 66);
      run_op("divu_100_7", 5, 64'd100, 64'd7, 64'd14, 66);
      run_op("divw_ovf", 9, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
      run_op("div_by0", 4, 64'd1234, 64'd0, '1, 1);
      run_op("remu_by0", 7, 64'd5, 64'd0, 64'd5, 1);
      run_op("mulw", 8, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 34);
      run_op("remuw", 12, 64'd17, 64'd5, 64'd2, 34);

      // Flush in the middle of a divide, then a fresh request right after.
      set_op(4); src1 = 64'd1000; src2 = 64'd3; muldiv_valid = 1'b1;
      saw = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         @(negedge clk);
         if (muldivout_valid) saw = 1'b1;
      end
      muldiv_flush = 1'b1;
      tick();
      muldiv_flush = 1'b0;
      muldiv_valid = 1'b0;
      @(negedge clk);
      chk("flush_ready21", {63'b0, muldiv_ready}, 64'd1);
      chk("flush_no_valid", {63'b0, saw}, 64'd0);
      run_op("after_flush", 5, 64'd100, 64'd7, 64'd14, 66);

      // Synchronous reset in the middle of a multiply.
      set_op(0); src1 = 64'd123; src2 = 64'd456; muldiv_valid = 1'b1;
      repeat (10) tick();
      rst_n = 1'b0;
      muldiv_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {63'b0, muldiv_ready}, 64'd1);
      chk("midrst_valid", {63'b0, muldivout_valid}, 64'd0);
      chk("midrst_result", muldiv_result, 64'd0);
      tick();

      // Back-to-back: each request appears the cycle after the previous result.
      run_op("b2b_1", 10, 64'd50, 64'd7, 64'd7, 34);
      run_op("b2b_2", 6, 64'd50, 64'd0, 64'd50, 1);
      run_op("b2b_3", 11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 34);

      for (int i = 0; i < 9000; i++) begin
         if (!muldiv_valid || $urandom_range(0, 3) == 0) begin
            set_op($urandom_range(0, 12));
            src1 = rand_opnd();
            src2 = rand_opnd();
            muldiv_valid = ($urandom_range(0, 3) != 0);
         end
         muldiv_flush = ($urandom_range(0, 299) == 0);
         tick();
      end
      muldiv_valid = 1'b0;
      muldiv_flush = 1'b0;
      repeat (80) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
